// File: rtl/pipe_pkg.sv
// Shared pipeline payload definitions: default payload width, the NOP bubble
// value, and the PC / instruction field positions inside a payload word.
package pipe_pkg;

  // Default payload: PC in the high half, instruction word in the low half.
  localparam int PIPE_DATA_W = 64;

  // Bubble payload loaded on reset and flush.
  localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;

  // Field offsets inside the default payload.
  localparam int PC_MSB    = 63;
  localparam int PC_LSB    = 32;
  localparam int INSTR_MSB = 31;
  localparam int INSTR_LSB = 0;
  localparam int PC_W      = PC_MSB - PC_LSB + 1;
  localparam int INSTR_W   = INSTR_MSB - INSTR_LSB + 1;

  // Extract the PC field of a default-width payload.
  function automatic logic [PC_W-1:0] pipe_pc(input logic [PIPE_DATA_W-1:0] payload);
    return payload[PC_MSB:PC_LSB];
  endfunction

  // Extract the instruction field of a default-width payload.
  function automatic logic [INSTR_W-1:0] pipe_instr(input logic [PIPE_DATA_W-1:0] payload);
    return payload[INSTR_MSB:INSTR_LSB];
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage entry of the pipeline stage: a valid bit plus a payload
// register. clear inserts a bubble (valid=0, payload=RESET_DATA) and wins
// over load; drop only retires the entry and keeps the payload visible.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = PIPE_DATA_W,
  parameter logic [DATA_W-1:0]  RESET_DATA = DATA_W'(PIPE_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  // Entry state: reset/clear give a bubble, load captures, drop retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_DATA;
    end else if (clear) begin
      valid_reg <= 1'b0;
      data_reg  <= RESET_DATA;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (drop) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble-inserting flush.
// Build option PIPE_STAGE_SKID_EN adds a skid entry so that in_ready comes
// from a register instead of combinationally from out_ready. Without it the
// stage has a single entry and in_ready follows out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = PIPE_DATA_W,
  parameter logic [DATA_W-1:0]  RESET_DATA = DATA_W'(PIPE_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_drop;
  logic [DATA_W-1:0] main_load_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  // Main (output-facing) entry; flush overrides any transfer this edge.
  pipe_skid_entry #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (main_load),
    .drop      (main_drop),
    .load_data (main_load_data),
    .valid     (main_valid),
    .data      (main_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_drop;

  // Ready depends only on the registered skid state (plus flush/reset).
  assign in_ready = !rst && !flush && !skid_valid;

  // When the main entry frees up it takes the skid payload first, keeping
  // order; an accepted input lands in skid only while the output stalls.
  always_comb begin
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_load_data = in_data;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (!main_valid || out_xfer) begin
      if (skid_valid) begin
        main_load      = 1'b1;
        main_load_data = skid_data;
        skid_drop      = 1'b1;
      end else if (in_xfer) begin
        main_load = 1'b1;
      end else begin
        main_drop = 1'b1;
      end
    end else if (in_xfer) begin
      skid_load = 1'b1;
    end
  end

  // Overflow entry catching the payload accepted during a stall.
  pipe_skid_entry #(
    .DATA_W     (DATA_W),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (skid_load),
    .drop      (skid_drop),
    .load_data (in_data),
    .valid     (skid_valid),
    .data      (skid_data)
  );
`else
  // Single entry: accept when empty or when the held payload leaves now.
  assign in_ready = !rst && !flush && (out_ready || !main_valid);

  // Load on input transfer (also covers simultaneous in/out), else retire.
  always_comb begin
    main_load      = in_xfer;
    main_drop      = out_xfer;
    main_load_data = in_data;
  end
`endif

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for single-cycle
// behaviour plus hand sequences for backpressure, flush collision,
// mid-cycle reset and the parameter sweep. Works with or without
// PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;

  // Sweep instances.
  logic        in_valid_p;
  logic        out_ready_p;
  logic [31:0] in_data32;
  logic [95:0] in_data96;
  logic        in_ready32, out_valid32;
  logic [31:0] out_data32;
  logic        in_ready96, out_valid96;
  logic [95:0] out_data96;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  pipe_stage_reg #(.DATA_W(32), .RESET_DATA(32'h13)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_p), .in_data(in_data32),
    .in_ready(in_ready32), .out_valid(out_valid32), .out_data(out_data32), .out_ready(out_ready_p)
  );

  pipe_stage_reg #(.DATA_W(96), .RESET_DATA(96'h13)) dut96 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_p), .in_data(in_data96),
    .in_ready(in_ready96), .out_valid(out_valid96), .out_data(out_data96), .out_ready(out_ready_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        exp_ir;
    logic        exp_ov;
    logic [63:0] exp_od;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive on negedge, check in_ready before the edge, outputs after.
  task automatic step(input string tag, input logic f, input logic iv, input logic [63:0] d,
                      input logic ordy, input logic exp_ir, input logic exp_ov,
                      input logic [63:0] exp_od);
    @(negedge clk);
    flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    check({tag, " in_ready"}, in_ready, exp_ir);
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, out_valid, exp_ov);
    check({tag, " out_data"}, out_data, exp_od);
    $display("txn %s: flush=%0b in_v=%0b in_d=%0h out_r=%0b -> out_valid=%0b out_data=%0h",
             tag, f, iv, d, ordy, out_valid, out_data);
  endtask

  initial begin
    //           flush in_v in_data      out_r ir ov out_data
    vecs[0]  = '{1'b0, 1'b1, 64'h1,  1'b1, 1'b1, 1'b1, 64'h1};
    vecs[1]  = '{1'b0, 1'b1, 64'h2,  1'b1, 1'b1, 1'b1, 64'h2};
    vecs[2]  = '{1'b0, 1'b1, 64'h3,  1'b1, 1'b1, 1'b1, 64'h3};
    vecs[3]  = '{1'b0, 1'b1, 64'h4,  1'b1, 1'b1, 1'b1, 64'h4};
    vecs[4]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h4};
    vecs[5]  = '{1'b0, 1'b1, 64'h10, 1'b0, 1'b1, 1'b1, 64'h10};
    vecs[6]  = '{1'b0, 1'b1, 64'h20, 1'b1, 1'b1, 1'b1, 64'h20};
    vecs[7]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h20};
    vecs[8]  = '{1'b0, 1'b1, 64'h30, 1'b0, 1'b1, 1'b1, 64'h30};
    vecs[9]  = '{1'b1, 1'b1, 64'h55, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[10] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid_p = 1'b0; out_ready_p = 1'b0; in_data32 = '0; in_data96 = '0;

    // Reset state.
    #2;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 64'h0);
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_data32", out_data32, 32'h13);
    check("reset out_data96", out_data96, 96'h13);
    check("reset out_valid96", out_valid96, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: streaming, drain, simultaneous transfer, flush.
    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), vecs[i].flush, vecs[i].in_valid, vecs[i].in_data,
           vecs[i].out_ready, vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_od);
    end

    // Backpressure: 0xA then 0xB offered while out_ready=0 for 3 cycles.
    step("bp1", 1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 64'hA);
    step("bp2", 1'b0, 1'b1, 64'hB, 1'b0, SKID, 1'b1, 64'hA);
    step("bp3", 1'b0, !SKID, 64'hB, 1'b0, 1'b0, 1'b1, 64'hA);
    step("bp4", 1'b0, !SKID, 64'hB, 1'b1, !SKID, 1'b1, 64'hB);
    step("bp5", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'hB);

    // Flush collision with a full stage.
    step("fc1", 1'b0, 1'b1, 64'h61, 1'b0, 1'b1, 1'b1, 64'h61);
    step("fc2", 1'b0, 1'b1, 64'h62, 1'b0, SKID, 1'b1, 64'h61);
    step("fc3", 1'b1, 1'b1, 64'h55, 1'b0, 1'b0, 1'b0, 64'h0);
    step("fc4", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0);
    step("fc5", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0);

    // Reset asserted mid-cycle while holding a payload.
    step("rs1", 1'b0, 1'b1, 64'hDEADBEEF_00000013, 1'b0, 1'b1, 1'b1, 64'hDEADBEEF_00000013);
    $display("txn rs1 pc=%0h instr=%0h", pipe_pc(out_data), pipe_instr(out_data));
    #1;
    rst = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst out_data", out_data, 64'h0);
    check("midrst in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h99; out_ready = 1'b1;
    #1;
    check("inrst in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("inrst out_valid", out_valid, 1'b0);
    check("inrst out_data", out_data, 64'h0);
    $display("txn rst held: out_valid=%0b out_data=%0h", out_valid, out_data);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 64'h42; out_ready = 1'b1;
    #1;
    check("first in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("first out_valid", out_valid, 1'b1);
    check("first out_data", out_data, 64'h42);
    $display("txn first accept: out_valid=%0b out_data=%0h", out_valid, out_data);

    // Parameter sweep: load then flush back to RESET_DATA=0x13.
    @(negedge clk);
    in_valid = 1'b0;
    in_valid_p = 1'b1; in_data32 = 32'hABC; in_data96 = 96'h1_0000_0000_0000_0ABC;
    @(posedge clk);
    #1;
    check("sweep load32", out_data32, 32'hABC);
    check("sweep load96", out_data96, 96'h1_0000_0000_0000_0ABC);
    @(negedge clk);
    in_valid_p = 1'b0; flush = 1'b1;
    #1;
    check("sweep in_ready32", in_ready32, 1'b0);
    @(posedge clk);
    #1;
    check("sweep flush32 data", out_data32, 32'h13);
    check("sweep flush32 valid", out_valid32, 1'b0);
    check("sweep flush96 data", out_data96, 96'h13);
    check("sweep flush96 valid", out_valid96, 1'b0);
    $display("txn sweep flush: d32=%0h d96=%0h", out_data32, out_data96);
    @(negedge clk);
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the payload width (PC plus instruction word).
REQ-002 The block SHALL have parameter RESET_DATA, default all-zero, giving the payload value loaded on reset and flush (the NOP bubble).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port flush  input  1  SHALL be a synchronous bubble-insert request.
REQ-006 Port in_valid  input  1  SHALL mean that upstream presents a payload.
REQ-007 Port in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-008 Port in_ready  output  1  SHALL mean that the stage accepts the payload this cycle.
REQ-009 Port out_valid  output  1  SHALL mean that the stage holds a valid payload.
REQ-010 Port out_data  output  DATA_W  SHALL carry the held payload.
REQ-011 Port out_ready  input  1  SHALL mean that downstream consumes out_data this cycle.

Function
REQ-012 An input transfer SHALL occur when in_valid=1 and in_ready=1 at a rising clk; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-013 Latency from input transfer to out_valid SHALL be 1 cycle when the stage was empty or draining.
REQ-014 out_data SHALL be stable while out_valid=1 and out_ready=0; no payload SHALL be dropped or duplicated.
REQ-015 When out_valid=0, out_data SHALL hold its last value (RESET_DATA after reset or flush).
REQ-016 flush=1 SHALL force in_ready=0 combinationally.
REQ-017 flush=1 SHALL, at the next edge, clear every valid bit and load RESET_DATA into out_data.
REQ-018 flush SHALL take priority over any simultaneous input or output transfer; the input payload SHALL be discarded.
REQ-019 in_valid=1 with in_ready=0 SHALL cause no state change; the upstream holds its payload.
REQ-020 Simultaneous input and output transfers SHALL replace out_data in the same edge, with out_valid remaining 1.
REQ-021 in_ready SHALL be undefined-free (never X) for all inputs after reset deassertion.

Reset
REQ-022 While rst=1, outputs SHALL be out_valid=0 and out_data=RESET_DATA; the skid buffer SHALL be empty.
REQ-023 While rst=1, in_ready SHALL be 0.
REQ-024 Reset assertion mid-transfer SHALL discard all held payloads immediately, without waiting for clk.
REQ-025 The first acceptance SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN SHALL select the ready-path implementation.
REQ-027 Without PIPE_STAGE_SKID_EN: in_ready = !flush && (out_ready || !out_valid) (combinational path from out_ready); one storage entry.
REQ-028 With PIPE_STAGE_SKID_EN: a second skid entry SHALL be present, and in_ready = !flush && !skid_valid, driven from a register with no out_ready-to-in_ready combinational path.
REQ-029 Skid behaviour: an input transfer while out_valid=1 and out_ready=0 SHALL go to the skid entry; on the next output transfer the skid entry SHALL move to out_data, in order.
REQ-030 Skid behaviour: the skid entry SHALL be cleared by flush and rst as in REQ-017/REQ-022.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the default payload-width constant, the NOP/bubble constant, and the payload field offsets (PC high half, instruction low half).
REQ-032 One sub-module, pipe_skid_entry (one valid bit plus payload register with load/clear), SHALL be instantiated once for the main entry and, when PIPE_STAGE_SKID_EN is defined, once for the skid entry.

Verification
REQ-033 Reset: assert rst mid-cycle while out_valid=1 with data 0xDEADBEEF_00000013 -> out_valid=0 and out_data=0 immediately; in_ready=0 until deassert.
REQ-034 Streaming: in_valid=1 and out_ready=1 held with payloads 1,2,3,4 -> out_data=1,2,3,4 on consecutive cycles, starting 1 cycle after the first acceptance.
REQ-035 Backpressure: out_ready=0 for 3 cycles while 0xA, 0xB are offered -> with skid, both accepted, out_data=0xA held, and 0xB emitted next after out_ready rises; without skid, only 0xA accepted and in_ready=0.
REQ-036 Flush collision: flush=1, in_valid=1 (0x55), out_ready=0, stage full -> next cycle out_valid=0, out_data=RESET_DATA, skid empty, 0x55 not seen later.
REQ-037 Simultaneous transfer: stage holds 0x10, in 0x20 with out_ready=1 -> next cycle out_valid=1 and out_data=0x20, with no bubble cycle.
REQ-038 Parameter sweep: DATA_W=32 and 96 with RESET_DATA=0x13 -> reset and flush values match RESET_DATA.
